// File: rtl/loom_dpi_pkg.sv
// Shared types and register map for the DPI call register file.
// Optional build macro LOOM_DPI_TIMEOUT_EN enables per-slot pending timeouts.
package loom_dpi_pkg;

    typedef enum logic [1:0] {
        SlotIdle    = 2'd0,
        SlotPending = 2'd1,
        SlotDone    = 2'd2
    } slot_state_e;

    // Per-slot register index (byte offset >> 2)
    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_ARG0   = 4'h1;
    localparam logic [3:0] REG_ARG7   = 4'h8;
    localparam logic [3:0] REG_RET_LO = 4'h9;
    localparam logic [3:0] REG_RET_HI = 4'hA;
    localparam logic [3:0] REG_CTRL   = 4'hB;

    // Global window register index
    localparam logic [3:0] REG_PEND_MASK = 4'h0;
    localparam logic [3:0] REG_N_FUNCS   = 4'h1;
    localparam logic [3:0] REG_VERSION   = 4'h2;

    localparam logic [5:0]  GLOBAL_SLOT     = 6'd63;
    localparam logic [63:0] DPI_RET_TIMEOUT = 64'hDEAD_DEAD_DEAD_DEAD;
    localparam logic [31:0] REGFILE_VERSION = 32'h0001_0000;

    function automatic logic [2:0] status_bits(input slot_state_e st, input logic timeout);
        return {timeout, (st == SlotDone), (st == SlotPending)};
    endfunction

endpackage

// File: rtl/loom_dpi_slot.sv
// One DPI call slot: call/complete/return FSM with argument and result storage.
// With LOOM_DPI_TIMEOUT_EN a pending call is force-completed after TIMEOUT_CYCLES.
module loom_dpi_slot
    import loom_dpi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1048576
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             call_valid_i,
    output logic             call_ready_o,
    input  logic [7:0][31:0] call_args_i,
    output logic             ret_valid_o,
    input  logic             ret_ready_i,
    output logic [63:0]      ret_data_o,
    input  logic             wr_ret_lo_i,
    input  logic             wr_ret_hi_i,
    input  logic             complete_i,
    input  logic [31:0]      wdata_i,
    output logic [7:0][31:0] args_o,
    output logic [2:0]       status_o,
    output logic             pending_o
);

    slot_state_e      state_q;
    logic [7:0][31:0] args_q;
    logic [63:0]      ret_q;
    logic             timeout_q;

`ifdef LOOM_DPI_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 32'd1);
    logic [31:0] cnt_q;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

    // Slot FSM with argument latch, result capture and optional timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SlotIdle;
            args_q    <= '0;
            ret_q     <= 64'd0;
            timeout_q <= 1'b0;
`ifdef LOOM_DPI_TIMEOUT_EN
            cnt_q     <= 32'd0;
`endif
        end else begin
            case (state_q)
                SlotIdle: begin
                    if (call_valid_i) begin
                        state_q   <= SlotPending;
                        args_q    <= call_args_i;
                        timeout_q <= 1'b0;
`ifdef LOOM_DPI_TIMEOUT_EN
                        cnt_q     <= 32'd0;
`endif
                    end
                end
                SlotPending: begin
                    if (wr_ret_lo_i) ret_q[31:0]  <= wdata_i;
                    if (wr_ret_hi_i) ret_q[63:32] <= wdata_i;
                    // A host complete on the expiry cycle takes priority over the timeout
                    if (complete_i) begin
                        state_q <= SlotDone;
                    end
`ifdef LOOM_DPI_TIMEOUT_EN
                    else if (cnt_q == TimeoutLast) begin
                        state_q   <= SlotDone;
                        ret_q     <= DPI_RET_TIMEOUT;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
`endif
                end
                SlotDone: begin
                    if (ret_ready_i) state_q <= SlotIdle;
                end
                default: state_q <= SlotIdle;
            endcase
        end
    end

    assign call_ready_o = (state_q == SlotIdle);
    assign ret_valid_o  = (state_q == SlotDone);
    assign pending_o    = (state_q == SlotPending);
    assign ret_data_o   = ret_q;
    assign args_o       = args_q;
    assign status_o     = status_bits(state_q, timeout_q);

endmodule

// File: rtl/loom_dpi_regfile.sv
// Host-visible DPI call register file: one slot per DPI function plus a global window.
// Build macro LOOM_DPI_TIMEOUT_EN enables the per-slot pending timeout.
module loom_dpi_regfile
    import loom_dpi_pkg::*;
#(
    parameter int unsigned N_DPI_FUNCS    = 32'd2,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1048576
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [N_DPI_FUNCS-1:0]            dpi_call_valid_i,
    output logic [N_DPI_FUNCS-1:0]            dpi_call_ready_o,
    input  logic [N_DPI_FUNCS-1:0][7:0][31:0] dpi_call_args_i,
    output logic [N_DPI_FUNCS-1:0]            dpi_ret_valid_o,
    input  logic [N_DPI_FUNCS-1:0]            dpi_ret_ready_i,
    output logic [N_DPI_FUNCS-1:0][63:0]      dpi_ret_data_o,
    input  logic                              host_req_i,
    input  logic                              host_we_i,
    input  logic [11:0]                       host_addr_i,
    input  logic [31:0]                       host_wdata_i,
    output logic [31:0]                       host_rdata_o,
    output logic                              host_rvalid_o,
    output logic                              irq_o
);

    logic [5:0]                        slot_s;
    logic [3:0]                        reg_s;
    logic [2:0]                        arg_idx_s;
    logic                              arg_sel_s;
    logic                              wr_s;
    logic [N_DPI_FUNCS-1:0]            hit_s;
    logic [N_DPI_FUNCS-1:0]            pend_s;
    logic [N_DPI_FUNCS-1:0][2:0]       status_s;
    logic [N_DPI_FUNCS-1:0][7:0][31:0] args_s;
    logic [31:0]                       pend_mask_s;
    logic [31:0]                       word_s;
    logic [31:0]                       rd_s;
    logic [31:0]                       rdata_q;
    logic                              rvalid_q;
    logic                              irq_q;
    logic [1:0]                        unused_addr_s;

    assign slot_s        = host_addr_i[11:6];
    assign reg_s         = host_addr_i[5:2];
    assign unused_addr_s = host_addr_i[1:0];
    assign arg_idx_s     = 3'(reg_s - REG_ARG0);
    assign arg_sel_s     = (reg_s >= REG_ARG0) && (reg_s <= REG_ARG7);
    assign wr_s          = host_req_i & host_we_i;
    assign pend_mask_s   = 32'(pend_s);

    for (genvar g = 0; g < N_DPI_FUNCS; g++) begin : g_slot
        assign hit_s[g] = (slot_s == 6'(g));

        loom_dpi_slot #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_slot (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .call_valid_i (dpi_call_valid_i[g]),
            .call_ready_o (dpi_call_ready_o[g]),
            .call_args_i  (dpi_call_args_i[g]),
            .ret_valid_o  (dpi_ret_valid_o[g]),
            .ret_ready_i  (dpi_ret_ready_i[g]),
            .ret_data_o   (dpi_ret_data_o[g]),
            .wr_ret_lo_i  (wr_s & hit_s[g] & (reg_s == REG_RET_LO)),
            .wr_ret_hi_i  (wr_s & hit_s[g] & (reg_s == REG_RET_HI)),
            .complete_i   (wr_s & hit_s[g] & (reg_s == REG_CTRL) & host_wdata_i[0]),
            .wdata_i      (host_wdata_i),
            .args_o       (args_s[g]),
            .status_o     (status_s[g]),
            .pending_o    (pend_s[g])
        );
    end

    // Read mux over the global window and all slot windows; unmapped reads return 0
    always_comb begin
        rd_s   = 32'd0;
        word_s = 32'd0;
        if (slot_s == GLOBAL_SLOT) begin
            case (reg_s)
                REG_PEND_MASK: rd_s = pend_mask_s;
                REG_N_FUNCS:   rd_s = 32'(N_DPI_FUNCS);
                REG_VERSION:   rd_s = REGFILE_VERSION;
                default:       rd_s = 32'd0;
            endcase
        end else begin
            for (int i = 0; i < int'(N_DPI_FUNCS); i++) begin
                case (reg_s)
                    REG_STATUS: word_s = {29'd0, status_s[i]};
                    REG_RET_LO: word_s = dpi_ret_data_o[i][31:0];
                    REG_RET_HI: word_s = dpi_ret_data_o[i][63:32];
                    default: begin
                        if (arg_sel_s) begin
                            word_s = args_s[i][arg_idx_s];
                        end else begin
                            word_s = 32'd0;
                        end
                    end
                endcase
                rd_s = rd_s | (word_s & {32{hit_s[i]}});
            end
        end
    end

    // Registered host response and interrupt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rvalid_q <= host_req_i;
            irq_q    <= |pend_s;
            if (host_req_i && !host_we_i) begin
                rdata_q <= rd_s;
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    assign host_rdata_o  = rdata_q;
    assign host_rvalid_o = rvalid_q;
    assign irq_o         = irq_q;

endmodule
